// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PA-RISC style PC/nPC fetch stage with IF/ID register
module fetch_pc_unit #(
  parameter int          ADDR_W   = 9,
  parameter int          INSTR_W  = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               le,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               flush,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_instr,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic               ifid_valid,
  output logic               misalign
);

  localparam logic [ADDR_W-1:0] RESET_PC_V  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] RESET_NPC_V = ADDR_W'(RESET_PC + 4);

  typedef enum logic {BOOT, RUN} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  npc_q, npc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               misalign_q, misalign_d;

  logic               advance;
  logic               stall_kill;
  logic [ADDR_W-1:0]  target_aligned;

  // State register: BOOT after reset, RUN thereafter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Next state: BOOT lasts exactly one edge regardless of le
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // FSM outputs: advance the fetch queue, or only drop ifid_valid while stalled
  always_comb begin
    advance    = 1'b0;
    stall_kill = 1'b0;
    if (state_q == RUN) begin
      advance    = le;
      stall_kill = ~le & flush;
    end
  end

  assign target_aligned = {branch_target[ADDR_W-1:2], 2'b00};

  // Datapath next-state: PC takes nPC; nPC takes redirect or sequential successor
  always_comb begin
    pc_d         = pc_q;
    npc_d        = npc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    misalign_d   = misalign_q;
    if (advance) begin
      pc_d         = npc_q;
      npc_d        = branch_taken ? target_aligned : npc_q + ADDR_W'(4);
      ifid_instr_d = flush ? '0 : rom_instr;
      ifid_pc_d    = pc_q;
      ifid_valid_d = ~flush;
      misalign_d   = misalign_q | (branch_taken & |branch_target[1:0]);
    end else if (stall_kill) begin
      ifid_valid_d = 1'b0;
    end
  end

  // Datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC_V;
      npc_q        <= RESET_NPC_V;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign rom_addr   = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        le;
  logic        branch_taken;
  logic [8:0]  branch_target;
  logic        flush;
  logic [8:0]  rom_addr;
  logic [31:0] rom_instr;
  logic [31:0] ifid_instr;
  logic [8:0]  ifid_pc;
  logic        ifid_valid;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  // model state
  int          m_pc, m_npc, m_ifid_pc;
  logic [31:0] m_ifid_instr;
  logic        m_valid, m_mis, m_boot;

  fetch_pc_unit #(.ADDR_W(9), .INSTR_W(32), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .le(le), .branch_taken(branch_taken),
    .branch_target(branch_target), .flush(flush), .rom_addr(rom_addr),
    .rom_instr(rom_instr), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_valid(ifid_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [8:0] a);
    return {a[8:2], 9'h0AB, 7'h00, a};
  endfunction

  always_comb rom_instr = rom_f(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_npc = 4; m_ifid_pc = 0; m_ifid_instr = 0;
    m_valid = 0; m_mis = 0; m_boot = 1;
  endtask

  task automatic model_edge();
    int old_pc;
    if (m_boot) begin
      m_boot = 0;
    end else if (le) begin
      old_pc       = m_pc;
      m_ifid_instr = flush ? 32'h0 : rom_f(9'(old_pc));
      m_ifid_pc    = old_pc;
      m_valid      = !flush;
      if (branch_taken && (branch_target % 4 != 0)) m_mis = 1;
      m_pc  = m_npc;
      m_npc = branch_taken ? (int'(branch_target) / 4) * 4 : (m_npc + 4) % 512;
    end else if (flush) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic l, input logic b, input logic [8:0] t, input logic f);
    le = l; branch_taken = b; branch_target = t; flush = f;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 9'h0, 1'b0);
  endtask

  // Compare every cycle against the model, away from the rising edge
  always @(negedge clk) begin
    chk("rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("ifid_instr", ifid_instr, m_ifid_instr);
    chk("ifid_pc", 32'(ifid_pc), 32'(m_ifid_pc));
    chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
    chk("misalign", 32'(misalign), 32'(m_mis));
  end

  initial begin
    rst_n = 1'b0; le = 1'b1; branch_taken = 1'b0; branch_target = 9'h0; flush = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;

    // 1: boot then sequential fetch W0..W3
    step(1'b1, 1'b0, 9'h0, 1'b0);
    chk("boot_valid", 32'(ifid_valid), 32'h0);
    chk("boot_rom_addr", 32'(rom_addr), 32'h0);
    run(1); chk("t1_pc0", 32'(ifid_pc), 32'd0); chk("t1_w0", ifid_instr, 32'h00AB0000);
    chk("t1_valid", 32'(ifid_valid), 32'h1);
    run(1); chk("t1_pc1", 32'(ifid_pc), 32'd4); chk("t1_w1", ifid_instr, 32'h02AB0004);
    run(1); chk("t1_pc2", 32'(ifid_pc), 32'd8); chk("t1_w2", ifid_instr, 32'h04AB0008);
    run(1); chk("t1_pc3", 32'(ifid_pc), 32'd12); chk("t1_w3", ifid_instr, 32'h06AB000C);

    // mid-cycle reset, then 2: delayed branch from PC=8,nPC=12
    rst_n = 1'b0; model_reset(); #1;
    @(negedge clk); #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 9'h0, 1'b0);
    run(2);
    step(1'b1, 1'b1, 9'h040, 1'b0); chk("t2_a", 32'(ifid_pc), 32'd8);
    run(1); chk("t2_delay_slot", 32'(ifid_pc), 32'd12);
    run(1); chk("t2_target", 32'(ifid_pc), 32'h40);
    run(1); chk("t2_target4", 32'(ifid_pc), 32'h44);

    // 3: stall with pending branch, flush during stall
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 9'h080, 1'b0);
    chk("t3_hold_pc", 32'(ifid_pc), 32'h44);
    chk("t3_hold_instr", ifid_instr, 32'h22AB0044);
    chk("t3_hold_rom", 32'(rom_addr), 32'h48);
    step(1'b0, 1'b1, 9'h080, 1'b1);
    chk("t3_flush_valid", 32'(ifid_valid), 32'h0);
    chk("t3_flush_instr", ifid_instr, 32'h22AB0044);
    step(1'b1, 1'b1, 9'h080, 1'b0); chk("t3_resume", 32'(ifid_pc), 32'h48);
    run(1); chk("t3_slot", 32'(ifid_pc), 32'h4C);
    run(1); chk("t3_target", 32'(ifid_pc), 32'h80);

    // 4: wrap-around from 504
    step(1'b1, 1'b1, 9'd504, 1'b0);
    run(1);
    run(1); chk("t4_504", 32'(ifid_pc), 32'd504);
    run(1); chk("t4_508", 32'(ifid_pc), 32'd508);
    run(1); chk("t4_wrap", 32'(ifid_pc), 32'd0);

    // 5: misaligned target together with flush
    step(1'b1, 1'b1, 9'h042, 1'b1);
    chk("t5_squash_valid", 32'(ifid_valid), 32'h0);
    chk("t5_squash_instr", ifid_instr, 32'h0);
    chk("t5_mis", 32'(misalign), 32'h1);
    run(1);
    run(1); chk("t5_aligned", 32'(ifid_pc), 32'h40);
    run(3); chk("t5_sticky", 32'(misalign), 32'h1);

    // 6: asynchronous reset between edges
    @(negedge clk); #2;
    rst_n = 1'b0; model_reset(); #1;
    chk("t6_rom_addr", 32'(rom_addr), 32'h0);
    chk("t6_valid", 32'(ifid_valid), 32'h0);
    chk("t6_mis", 32'(misalign), 32'h0);
    chk("t6_ifid_pc", 32'(ifid_pc), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(1'b0, 1'b0, 9'h0, 1'b0);
    chk("t6_boot_valid", 32'(ifid_valid), 32'h0);
    step(1'b1, 1'b0, 9'h0, 1'b0);
    chk("t6_first", 32'(ifid_pc), 32'h0);
    chk("t6_first_valid", 32'(ifid_valid), 32'h1);
    chk("t6_first_instr", ifid_instr, 32'h00AB0000);
    run(2);
    @(negedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
